noise_tolerant_encoder: RTL

NOISE_TOLERANT_ENCODER -- requirements
Module: noise_tolerant_encoder

---
 rtl/noise_tolerant_encoder_if.sv | 21 ++
 rtl/noise_tolerant_encoder.sv | 101 ++++++++++
 2 files changed

// File: rtl/noise_tolerant_encoder_if.sv
// Handshake and data bundle between a frame source and the Golay (24,12) encoder.
interface noise_tolerant_encoder_if;
  logic        enable;
  logic [11:0] input_vector;
  logic [23:0] error_mask;
  logic [23:0] output_vector;
  logic        ready;
  logic        finish;
  logic        serial_out;
  logic        serial_valid;

  modport master (
    output enable, input_vector, error_mask,
    input  output_vector, ready, finish, serial_out, serial_valid
  );

  modport slave (
    input  enable, input_vector, error_mask,
    output output_vector, ready, finish, serial_out, serial_valid
  );
endinterface

// File: rtl/noise_tolerant_encoder.sv
// Extended Golay (24,12) systematic encoder with optional error injection and
// an MSB-first serialiser; one frame per accepted enable, 26 cycles back-to-back.
module noise_tolerant_encoder (
  input  logic                     clk,
  input  logic                     rst_n,
  noise_tolerant_encoder_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENCODE = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;

  logic [1:0]  r_state;
  logic [11:0] r_data;
  logic [23:0] r_mask;
  logic [23:0] r_code;
  logic [23:0] r_shift;
  logic [4:0]  r_cnt;
  logic        r_ready;
  logic        r_finish;
  logic        r_valid;

  logic [11:0] w_parity;
  logic [23:0] w_code;

  // Each mask selects the message bits d[k] (= c[k+12]) feeding one parity bit.
  always_comb begin
    w_parity[11] = ^(r_data & 12'hFFE);
    w_parity[10] = ^(r_data & 12'hA3B);
    w_parity[9]  = ^(r_data & 12'hD1D);
    w_parity[8]  = ^(r_data & 12'h68F);
    w_parity[7]  = ^(r_data & 12'hB47);
    w_parity[6]  = ^(r_data & 12'hDA3);
    w_parity[5]  = ^(r_data & 12'hED1);
    w_parity[4]  = ^(r_data & 12'h769);
    w_parity[3]  = ^(r_data & 12'h3B5);
    w_parity[2]  = ^(r_data & 12'h1DB);
    w_parity[1]  = ^(r_data & 12'h8ED);
    w_parity[0]  = ^(r_data & 12'h477);
  end

  assign w_code = {r_data, w_parity} ^ r_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_mask   <= '0;
      r_code   <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_finish <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_finish <= 1'b0;
          if (bus.enable) begin
            r_data  <= bus.input_vector;
            r_mask  <= bus.error_mask;
            r_ready <= 1'b0;
            r_state <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          r_code  <= w_code;
          r_shift <= w_code;
          r_cnt   <= 5'd23;
          r_valid <= 1'b1;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          // Last bit has already been on the line for a full cycle when cnt hits 0.
          if (r_cnt == 5'd0) begin
            r_shift  <= '0;
            r_valid  <= 1'b0;
            r_finish <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_shift <= {r_shift[22:0], 1'b0};
            r_cnt   <= r_cnt - 5'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.output_vector = r_code;
  assign bus.ready         = r_ready;
  assign bus.finish        = r_finish;
  assign bus.serial_valid  = r_valid;
  assign bus.serial_out    = r_shift[23] & r_valid;

endmodule
